// File: rtl/ff_char_pkg.sv
// Shared types and tick arithmetic for the transmission-gate DFF setup sweeper.
// All tick numbers refer to the CK edge at which the phase counter holds that value.
package ff_char_pkg;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_PRIME = 2'd1,
        S_RUN   = 2'd2,
        S_DONE  = 2'd3
    } sweep_state_t;

    localparam int DEF_DIV         = 32;
    localparam int DEF_CAPTURE_DLY = 8;
    localparam int DEF_TRIALS      = 4;
    localparam int DEF_OFS_W       = 8;

    // D launches ofs ticks ahead of the DUT rising edge at DIV/2.
    function automatic int launch_tick(input int div, input int ofs);
        return div / 2 - ofs;
    endfunction

    function automatic int capture_tick(input int div, input int capture_dly);
        return div / 2 + capture_dly;
    endfunction

    function automatic bit cfg_ok(input int div, input int capture_dly,
                                  input int trials, input int ofs_w);
        return (div % 2 == 0) && (div >= 8) && (div <= 256) &&
               (capture_dly >= 1) && (capture_dly < div / 2) &&
               (trials >= 1) && (trials <= 16) &&
               (ofs_w >= 1) && (ofs_w <= 16) && ((div / 2 - 1) < (1 << ofs_w));
    endfunction

endpackage

// File: rtl/ff_char_phase_gen.sv
// Fast-timebase phase counter: DUT clock generation plus rise/launch/capture/wrap strobes.
// Strobes are single-cycle and refer to the CK edge at which ph equals the named tick.
module ff_char_phase_gen
    import ff_char_pkg::*;
#(
    parameter int DIV         = DEF_DIV,
    parameter int CAPTURE_DLY = DEF_CAPTURE_DLY,
    parameter int OFS_W       = DEF_OFS_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             active,
    input  logic             keep_ck,
    input  logic [OFS_W-1:0] ofs,
    output logic             ck_out,
    output logic             rise_stb,
    output logic             launch_stb,
    output logic             capture_stb,
    output logic             wrap_stb
);

    localparam int PH_W = $clog2(DIV);
    localparam logic [PH_W-1:0] PH_LAST = PH_W'(DIV - 1);
    localparam logic [PH_W-1:0] PH_RISE = PH_W'(DIV / 2);
    localparam logic [PH_W-1:0] PH_CAP  = PH_W'(capture_tick(DIV, CAPTURE_DLY));

    logic [PH_W-1:0] ph;
    logic [PH_W-1:0] ph_launch;
    logic            ck_q;

    // Recomputed combinationally so an offset change at capture is live before ph wraps.
    assign ph_launch = PH_W'(launch_tick(DIV, int'(ofs)));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ph <= '0;
        end else if (!active || ph == PH_LAST) begin
            ph <= '0;
        end else begin
            ph <= ph + 1'b1;
        end
    end

    // keep_ck drops on the edge that leaves PRIME/RUN so CK_OUT is already low in DONE.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ck_q <= 1'b0;
        end else begin
            ck_q <= active && keep_ck && (ph >= PH_RISE);
        end
    end

    assign ck_out      = ck_q;
    assign rise_stb    = active && (ph == PH_RISE);
    assign launch_stb  = active && (ph == ph_launch);
    assign capture_stb = active && (ph == PH_CAP);
    assign wrap_stb    = active && (ph == PH_LAST);

endmodule

// File: rtl/ff_setup_sweeper.sv
// Setup-time sweeper for the DFF model: drives CK_OUT/D_OUT, checks Q_IN, and
// walks the D-to-clock offset down from DIV/2-1 to find the smallest reliable one.
module ff_setup_sweeper
    import ff_char_pkg::*;
#(
    parameter int DIV         = DEF_DIV,
    parameter int CAPTURE_DLY = DEF_CAPTURE_DLY,
    parameter int TRIALS      = DEF_TRIALS,
    parameter int OFS_W       = DEF_OFS_W
) (
    input  logic             CK,
    input  logic             RSTB,
    input  logic             START,
    input  logic             Q_IN,
    output logic             CK_OUT,
    output logic             D_OUT,
    output logic             BUSY,
    output logic             DONE,
    output logic             PASS_ANY,
    output logic [OFS_W-1:0] SETUP_MIN,
    output logic [7:0]       FAIL_CNT,
    output logic [1:0]       dbg_state
);

    if (!cfg_ok(DIV, CAPTURE_DLY, TRIALS, OFS_W)) begin : g_bad_cfg
        $error("ff_setup_sweeper: illegal DIV/CAPTURE_DLY/TRIALS/OFS_W combination");
    end

    localparam logic [OFS_W-1:0] OFS_MAX    = OFS_W'(DIV / 2 - 1);
    localparam logic [OFS_W-1:0] OFS_MIN    = OFS_W'(1);
    localparam int               TR_W       = (TRIALS > 1) ? $clog2(TRIALS) : 1;
    localparam logic [TR_W-1:0]  TRIAL_LAST = TR_W'(TRIALS - 1);

    sweep_state_t     state;
    sweep_state_t     state_nxt;
    logic             armed;
    logic [OFS_W-1:0] ofs;
    logic [TR_W-1:0]  trial;
    logic             d_q;
    logic             d_at_rise;
    logic             pass_q;
    logic [OFS_W-1:0] min_q;
    logic [7:0]       fail_q;

    logic active;
    logic keep_ck;
    logic rise_stb;
    logic launch_stb;
    logic capture_stb;
    logic wrap_stb;
    logic cap_miss;
    logic cap_last;
    logic ofs_at_min;

    // Handshake: START is a one-cycle request honoured only in IDLE and only once
    // reset has been released for a full cycle; BUSY spans PRIME and RUN; DONE is a
    // single-cycle pulse, after which PASS_ANY/SETUP_MIN/FAIL_CNT hold until the next
    // accepted START.
    ff_char_phase_gen #(
        .DIV         (DIV),
        .CAPTURE_DLY (CAPTURE_DLY),
        .OFS_W       (OFS_W)
    ) u_phase (
        .clk         (CK),
        .rst_n       (RSTB),
        .active      (active),
        .keep_ck     (keep_ck),
        .ofs         (ofs),
        .ck_out      (CK_OUT),
        .rise_stb    (rise_stb),
        .launch_stb  (launch_stb),
        .capture_stb (capture_stb),
        .wrap_stb    (wrap_stb)
    );

    assign cap_miss   = (Q_IN != d_at_rise);
    assign cap_last   = (trial == TRIAL_LAST);
    assign ofs_at_min = (ofs == OFS_MIN);

    always_ff @(posedge CK or negedge RSTB) begin
        if (!RSTB) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (START && armed) state_nxt = S_PRIME;
            S_PRIME: if (wrap_stb) state_nxt = S_RUN;
            S_RUN:   if (capture_stb && (cap_miss || (cap_last && ofs_at_min))) state_nxt = S_DONE;
            S_DONE:  state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        active    = (state == S_PRIME) || (state == S_RUN);
        keep_ck   = (state_nxt == S_PRIME) || (state_nxt == S_RUN);
        BUSY      = active;
        DONE      = (state == S_DONE);
        dbg_state = state;
    end

    always_ff @(posedge CK or negedge RSTB) begin
        if (!RSTB) begin
            armed     <= 1'b0;
            ofs       <= '0;
            trial     <= '0;
            d_q       <= 1'b0;
            d_at_rise <= 1'b0;
            pass_q    <= 1'b0;
            min_q     <= '0;
            fail_q    <= '0;
        end else begin
            armed <= 1'b1;
            case (state)
                S_IDLE: begin
                    if (state_nxt == S_PRIME) begin
                        ofs    <= OFS_MAX;
                        trial  <= '0;
                        d_q    <= 1'b0;
                        pass_q <= 1'b0;
                        min_q  <= '0;
                        fail_q <= '0;
                    end
                end
                S_PRIME: begin
                    trial <= '0;
                end
                S_RUN: begin
                    if (launch_stb) d_q <= ~d_q;
                    if (rise_stb) d_at_rise <= d_q;
                    if (capture_stb) begin
                        if (cap_miss) begin
                            fail_q <= (fail_q == 8'hFF) ? fail_q : fail_q + 8'd1;
                        end else if (cap_last) begin
                            pass_q <= 1'b1;
                            min_q  <= ofs;
                            trial  <= '0;
                            if (!ofs_at_min) ofs <= ofs - 1'b1;
                        end else begin
                            trial <= trial + 1'b1;
                        end
                    end
                    if (state_nxt == S_DONE) d_q <= 1'b0;
                end
                S_DONE: begin
                    d_q <= 1'b0;
                end
                default: begin
                    d_q <= 1'b0;
                end
            endcase
        end
    end

    assign D_OUT     = d_q;
    assign PASS_ANY  = pass_q;
    assign SETUP_MIN = min_q;
    assign FAIL_CNT  = fail_q;

endmodule
